// File: rtl/csi2_pkg.sv
// Shared types, constants and helper functions for the CSI-2 packet parser.
// Holds the FSM state encoding, the ECC parity masks and the CRC-16 constants.
package csi2_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned HDR_W  = 24;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PLD,
    CRC,
    WAIT_END
  } state_e;

  // Parity masks over {WC_MSB, WC_LSB, DI}; entry i produces ECC bit i.
  localparam logic [5:0][HDR_W-1:0] ECC_MASKS = {
    24'hEFFC00,
    24'hDF03F0,
    24'hB8E38E,
    24'h749A6D,
    24'hF2555B,
    24'hF12CB7
  };

  localparam logic [CRC_W-1:0] CRC_POLY_REFL    = 16'h8408;
  localparam logic [CRC_W-1:0] CRC_SEED         = 16'hFFFF;
  localparam logic [5:0]       SHORT_DT_MAX_DEF = 6'h0F;

  function automatic logic [BYTE_W-1:0] ecc24(input logic [HDR_W-1:0] d);
    return {2'b00,
            ^(d & ECC_MASKS[5]), ^(d & ECC_MASKS[4]), ^(d & ECC_MASKS[3]),
            ^(d & ECC_MASKS[2]), ^(d & ECC_MASKS[1]), ^(d & ECC_MASKS[0])};
  endfunction

  // One byte of the reflected CRC-16, LSB first.
  function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] c,
                                                   input logic [BYTE_W-1:0] b);
    logic [CRC_W-1:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/csi2_packet_parser_if.sv
// PPI receive inputs and decoded packet outputs of the CSI-2 packet parser.
// master = upstream/observer side, slave = the parser itself.
interface csi2_packet_parser_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  RxActiveHS;
  logic                  RxSyncHS;
  logic                  RxValidHS;
  logic [DATA_WIDTH-1:0] RxDataHS;

  logic [1:0]            o_vc;
  logic [5:0]            o_dt;
  logic [15:0]           o_wc;
  logic                  o_short_pkt;
  logic                  o_hdr_valid;
  logic                  o_ecc_err;
  logic [7:0]            o_pld_data;
  logic                  o_pld_valid;
  logic                  o_pld_last;
  logic                  o_crc_valid;
  logic                  o_crc_err;
  logic                  o_pkt_err;

  modport master (
    output RxActiveHS, RxSyncHS, RxValidHS, RxDataHS,
    input  o_vc, o_dt, o_wc, o_short_pkt, o_hdr_valid, o_ecc_err,
    input  o_pld_data, o_pld_valid, o_pld_last, o_crc_valid, o_crc_err, o_pkt_err
  );

  modport slave (
    input  RxActiveHS, RxSyncHS, RxValidHS, RxDataHS,
    output o_vc, o_dt, o_wc, o_short_pkt, o_hdr_valid, o_ecc_err,
    output o_pld_data, o_pld_valid, o_pld_last, o_crc_valid, o_crc_err, o_pkt_err
  );
endinterface

// File: rtl/csi2_crc16.sv
// Byte-wide running CRC-16 (reflected 0x8408) with seed load and enable.
module csi2_crc16
  import csi2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic [CRC_W-1:0]  crc
);

  logic [CRC_W-1:0] crc_nx_c;

  always_comb begin
    crc_nx_c = crc16_byte(crc, data);
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC_SEED;
    end else if (en) begin
      crc <= crc_nx_c;
    end
  end

endmodule

// File: rtl/csi2_packet_parser.sv
// Splits each HS burst into CSI-2 header / payload / CRC, checks ECC and CRC-16,
// and streams qualified payload bytes with one cycle of latency.
module csi2_packet_parser
  import csi2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter logic [5:0]  SHORT_DT_MAX = SHORT_DT_MAX_DEF
) (
  input logic                 RxByteClkHS,
  input logic                 RST,
  csi2_packet_parser_if.slave bus
);

  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  acc_c;
  state_e                state_q, state_nx;
  logic [1:0]            idx_q, idx_nx;
  logic [7:0]            di_q, wc_lsb_q, wc_msb_q, crc_lsb_q;
  logic [15:0]           rem_q, wc_c, crc_q;
  logic                  is_short_c;
  logic                  crc_init_c, hdr_done_c, pld_byte_c, pld_end_c, crc_done_c, pkt_err_c;

  assign rx_byte    = bus.RxDataHS;
  assign acc_c      = bus.RxValidHS & bus.RxActiveHS;
  assign wc_c       = {wc_msb_q, wc_lsb_q};
  assign is_short_c = (di_q[5:0] <= SHORT_DT_MAX);

  csi2_crc16 u_crc (
    .clk  (RxByteClkHS),
    .rst  (RST),
    .init (crc_init_c),
    .en   (pld_byte_c),
    .data (rx_byte),
    .crc  (crc_q)
  );

  always_ff @(posedge RxByteClkHS) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_nx;
      idx_q   <= idx_nx;
    end
  end

  // Next state plus one-cycle event strobes for the datapath.
  always_comb begin
    state_nx   = state_q;
    idx_nx     = idx_q;
    crc_init_c = 1'b0;
    hdr_done_c = 1'b0;
    pld_byte_c = 1'b0;
    pld_end_c  = 1'b0;
    crc_done_c = 1'b0;
    pkt_err_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.RxSyncHS && bus.RxActiveHS) begin
          state_nx   = HDR;
          idx_nx     = 2'd0;
          crc_init_c = 1'b1;
        end
      end
      HDR: begin
        if (!bus.RxActiveHS) begin
          pkt_err_c = 1'b1;
          state_nx  = IDLE;
        end else if (acc_c) begin
          if (idx_q == 2'd3) begin
            hdr_done_c = 1'b1;
            idx_nx     = 2'd0;
            if (is_short_c)         state_nx = WAIT_END;
            else if (wc_c == 16'd0) state_nx = CRC;
            else                    state_nx = PLD;
          end else begin
            idx_nx = idx_q + 2'd1;
          end
        end
      end
      PLD: begin
        if (!bus.RxActiveHS) begin
          pkt_err_c = 1'b1;
          state_nx  = IDLE;
        end else if (acc_c) begin
          pld_byte_c = 1'b1;
          if (rem_q == 16'd1) begin
            pld_end_c = 1'b1;
            idx_nx    = 2'd0;
            state_nx  = CRC;
          end
        end
      end
      CRC: begin
        if (!bus.RxActiveHS) begin
          pkt_err_c = 1'b1;
          state_nx  = IDLE;
        end else if (acc_c) begin
          if (idx_q == 2'd1) begin
            crc_done_c = 1'b1;
            idx_nx     = 2'd0;
            state_nx   = WAIT_END;
          end else begin
            idx_nx = 2'd1;
          end
        end
      end
      WAIT_END: begin
        if (!bus.RxActiveHS) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Header capture, payload counter and registered outputs.
  always_ff @(posedge RxByteClkHS) begin
    if (RST) begin
      di_q            <= 8'h00;
      wc_lsb_q        <= 8'h00;
      wc_msb_q        <= 8'h00;
      crc_lsb_q       <= 8'h00;
      rem_q           <= 16'd0;
      bus.o_vc        <= 2'd0;
      bus.o_dt        <= 6'd0;
      bus.o_wc        <= 16'd0;
      bus.o_short_pkt <= 1'b0;
      bus.o_hdr_valid <= 1'b0;
      bus.o_ecc_err   <= 1'b0;
      bus.o_pld_data  <= 8'h00;
      bus.o_pld_valid <= 1'b0;
      bus.o_pld_last  <= 1'b0;
      bus.o_crc_valid <= 1'b0;
      bus.o_crc_err   <= 1'b0;
      bus.o_pkt_err   <= 1'b0;
    end else begin
      bus.o_hdr_valid <= hdr_done_c;
      bus.o_pld_valid <= pld_byte_c;
      bus.o_pld_last  <= pld_end_c;
      bus.o_crc_valid <= crc_done_c;
      bus.o_pkt_err   <= pkt_err_c;

      if (acc_c && state_q == HDR) begin
        case (idx_q)
          2'd0:    di_q     <= rx_byte;
          2'd1:    wc_lsb_q <= rx_byte;
          2'd2:    wc_msb_q <= rx_byte;
          default: ;
        endcase
      end

      if (hdr_done_c) begin
        bus.o_vc        <= di_q[7:6];
        bus.o_dt        <= di_q[5:0];
        bus.o_wc        <= wc_c;
        bus.o_short_pkt <= is_short_c;
        bus.o_ecc_err   <= (ecc24({wc_msb_q, wc_lsb_q, di_q}) != rx_byte);
        rem_q           <= wc_c;
      end

      if (pld_byte_c) begin
        bus.o_pld_data <= rx_byte;
        rem_q          <= rem_q - 16'd1;
      end

      if (acc_c && state_q == CRC && idx_q == 2'd0) begin
        crc_lsb_q <= rx_byte;
      end

      if (crc_done_c) begin
        bus.o_crc_err <= ({rx_byte, crc_lsb_q} != crc_q);
      end
    end
  end

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Directed bench for csi2_packet_parser: scoreboard queues for header, payload
// and CRC events plus per-cycle checks of o_pld_valid and o_pkt_err.
module tb_csi2_packet_parser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csi2_packet_parser_if #(.DATA_WIDTH(8)) bus ();

  csi2_packet_parser #(.DATA_WIDTH(8), .SHORT_DT_MAX(6'h0F)) dut (
    .RxByteClkHS (clk),
    .RST         (rst),
    .bus         (bus)
  );

  typedef struct packed {logic [7:0] data; logic last;} pld_t;
  typedef struct packed {logic [1:0] vc; logic [5:0] dt; logic [15:0] wc; logic sp; logic ecc;} hdr_t;

  int   vectors     = 0;
  int   miscompares = 0;
  pld_t pq[$];
  hdr_t hq[$];
  logic cq[$];
  logic pv_exp = 1'b0, pe_exp = 1'b0, pv_pipe = 1'b0, pe_pipe = 1'b0, mon_en = 1'b0;
  logic [7:0] pay [24];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    pv_pipe <= pv_exp;
    pe_pipe <= pe_exp;
  end

  // Output monitor: pops scoreboard entries as the DUT produces events.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pld_valid_timing", 32'(bus.o_pld_valid), 32'(pv_pipe));
      chk("pkt_err_timing", 32'(bus.o_pkt_err), 32'(pe_pipe));
      if (bus.o_pld_valid) begin
        chk("pld_expected", 32'(pq.size() != 0), 32'd1);
        if (pq.size() != 0) begin
          pld_t e;
          e = pq.pop_front();
          chk("pld_data", 32'(bus.o_pld_data), 32'(e.data));
          chk("pld_last", 32'(bus.o_pld_last), 32'(e.last));
        end
      end
      if (bus.o_hdr_valid) begin
        chk("hdr_expected", 32'(hq.size() != 0), 32'd1);
        if (hq.size() != 0) begin
          hdr_t h;
          h = hq.pop_front();
          chk("hdr_vc_dt", 32'({bus.o_vc, bus.o_dt}), 32'({h.vc, h.dt}));
          chk("hdr_wc", 32'(bus.o_wc), 32'(h.wc));
          chk("hdr_short", 32'(bus.o_short_pkt), 32'(h.sp));
          chk("hdr_ecc_err", 32'(bus.o_ecc_err), 32'(h.ecc));
        end
      end
      if (bus.o_crc_valid) begin
        chk("crc_expected", 32'(cq.size() != 0), 32'd1);
        if (cq.size() != 0) begin
          logic c;
          c = cq.pop_front();
          chk("crc_err", 32'(bus.o_crc_err), 32'(c));
        end
      end
    end
  end

  task automatic drive(input logic act, input logic sync, input logic vld,
                       input logic [7:0] d, input logic pld, input logic pe);
    @(negedge clk);
    bus.RxActiveHS = act;
    bus.RxSyncHS   = sync;
    bus.RxValidHS  = vld;
    bus.RxDataHS   = d;
    pv_exp         = pld;
    pe_exp         = pe;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_fields"}, 32'({bus.o_vc, bus.o_dt, bus.o_wc}), 32'd0);
    chk({tag, "_flags"}, 32'({bus.o_short_pkt, bus.o_hdr_valid, bus.o_ecc_err, bus.o_pld_data,
                              bus.o_pld_valid, bus.o_pld_last, bus.o_crc_valid, bus.o_crc_err,
                              bus.o_pkt_err}), 32'd0);
  endtask

  // Sync cycle carries a junk valid byte that must not enter the packet.
  task automatic start_pkt();
    drive(1'b1, 1'b1, 1'b1, 8'hB8, 1'b0, 1'b0);
  endtask

  task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc,
                          input logic [7:0] ecc, input logic sp, input logic ecc_err);
    hdr_t h;
    h.vc = di[7:6]; h.dt = di[5:0]; h.wc = wc; h.sp = sp; h.ecc = ecc_err;
    hq.push_back(h);
    drive(1'b1, 1'b0, 1'b1, di, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, wc[7:0], 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, wc[15:8], 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, ecc, 1'b0, 1'b0);
  endtask

  // Payload bytes; a stray sync on byte 3 must be ignored.
  task automatic send_pld(input int wc, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      pld_t e;
      if (gaps && i > 0) drive(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
      e.data = pay[i];
      e.last = (i == wc - 1);
      pq.push_back(e);
      drive(1'b1, (i == 3), 1'b1, pay[i], 1'b1, 1'b0);
    end
  endtask

  task automatic send_crc(input logic [7:0] lsb, input logic [7:0] msb, input logic err);
    cq.push_back(err);
    drive(1'b1, 1'b0, 1'b1, lsb, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, msb, 1'b0, 1'b0);
  endtask

  task automatic end_burst();
    drive(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic good_long_pkt(input bit gaps);
    start_pkt();
    send_hdr(8'h2A, 16'd24, 8'h13, 1'b0, 1'b0);
    send_pld(24, 24, gaps);
    send_crc(8'hF0, 8'h00, 1'b0);
    end_burst();
  endtask

  initial begin
    pay = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
            8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
            8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    bus.RxActiveHS = 1'b0;
    bus.RxSyncHS   = 1'b0;
    bus.RxValidHS  = 1'b0;
    bus.RxDataHS   = 8'h00;

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    // Short packet
    start_pkt();
    send_hdr(8'h00, 16'h0001, 8'h1A, 1'b1, 1'b0);
    end_burst();

    // Long packet, clean
    good_long_pkt(1'b0);

    // Long packet with one payload bit flipped
    pay[5] = pay[5] ^ 8'h10;
    start_pkt();
    send_hdr(8'h2A, 16'd24, 8'h13, 1'b0, 1'b0);
    send_pld(24, 24, 1'b0);
    send_crc(8'hF0, 8'h00, 1'b1);
    end_burst();
    pay[5] = pay[5] ^ 8'h10;

    // Corrupted ECC: flagged, payload still streams
    start_pkt();
    send_hdr(8'h2A, 16'd24, 8'h12, 1'b0, 1'b1);
    send_pld(24, 24, 1'b0);
    send_crc(8'hF0, 8'h00, 1'b0);
    end_burst();

    // RxValidHS gaps during payload
    good_long_pkt(1'b1);

    // RxActiveHS drops after 10 payload bytes
    start_pkt();
    send_hdr(8'h2A, 16'd24, 8'h13, 1'b0, 1'b0);
    send_pld(24, 10, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    good_long_pkt(1'b0);

    // WC = 0 long packet
    start_pkt();
    send_hdr(8'h2A, 16'd0, 8'h10, 1'b0, 1'b0);
    send_crc(8'hFF, 8'hFF, 1'b0);
    end_burst();

    // Reset in PLD: outputs clear, no pkt_err, parser back in IDLE
    start_pkt();
    send_hdr(8'h2A, 16'd24, 8'h13, 1'b0, 1'b0);
    send_pld(24, 5, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset_in_pld");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // WC = 1: single byte 0x00 carries last; CRC 0x0F87
    pay[0] = 8'h00;
    start_pkt();
    send_hdr(8'h2A, 16'd1, 8'h0A, 1'b0, 1'b0);
    send_pld(1, 1, 1'b0);
    send_crc(8'h87, 8'h0F, 1'b0);
    end_burst();

    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    mon_en = 1'b0;
    chk("pld_queue_drained", 32'(pq.size()), 32'd0);
    chk("hdr_queue_drained", 32'(hq.size()), 32'd0);
    chk("crc_queue_drained", 32'(cq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
